// File: rtl/frogger_vga_out.sv
// frogger_vga_out
// Display-side end of the Frogger video path. Generates the VGA raster
// (DrawX/DrawY) for the renderer, maps the renderer's 6-bit colorcode
// through the game palette and drives registered sync/blank/RGB to the DAC.
//
// Ports:
//   Clk          system clock (50 MHz)
//   Reset        synchronous, active-high
//   colorcode    palette index from the renderer (combinational on DrawX/DrawY)
//   DrawX, DrawY current pixel / line counters
//   VGA_CLK      pixel clock to the DAC (Clk/2)
//   VGA_HS/VS    active-low syncs
//   VGA_BLANK_N  high in the visible region
//   VGA_R/G/B    8-bit pixel colour
//   frame_start  one-Clk pulse when the raster wraps to (0,0)
module frogger_vga_out #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] colorcode,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic       pix_en;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       v_wrap;
    logic       visible;
    logic       hs_act;
    logic       vs_act;
    logic [23:0] pal_rgb;
    logic [23:0] rgb_q;

    // Pixel enable: one pixel every two Clk. Reset leaves it at 0, so the
    // first counter advance lands on the second edge after Reset drops.
    always_ff @(posedge Clk) begin
        if (Reset) pix_en <= 1'b0;
        else       pix_en <= ~pix_en;
    end

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? 10'd0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // High only on the edge that moves the raster from the last pixel of the
    // frame to (0,0); pix_en is low on the next edge, so it clears itself.
    always_ff @(posedge Clk) begin
        if (Reset) frame_start <= 1'b0;
        else       frame_start <= pix_en & h_wrap & v_wrap;
    end

    always_comb begin
        visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_act  = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
        vs_act  = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    end

    // Game palette; indices above 10 are black.
    always_comb begin
        pal_rgb = 24'h000000;
        case (colorcode)
            6'd0:    pal_rgb = 24'hffffff;
            6'd1:    pal_rgb = 24'h000000;
            6'd2:    pal_rgb = 24'h27b212;
            6'd3:    pal_rgb = 24'hd80222;
            6'd4:    pal_rgb = 24'h5db1f0;
            6'd5:    pal_rgb = 24'hf1ff0a;
            6'd6:    pal_rgb = 24'hb2b2b0;
            6'd7:    pal_rgb = 24'hf27a00;
            6'd8:    pal_rgb = 24'h663300;
            6'd9:    pal_rgb = 24'h8600b3;
            6'd10:   pal_rgb = 24'h000066;
            default: pal_rgb = 24'h000000;
        endcase
    end

    // Output register: captures decodes of the pixel being left on the
    // advancing edge, so sync/blank/RGB trail DrawX/DrawY by one pixel and
    // stay aligned with one another.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            rgb_q       <= '0;
        end else if (pix_en) begin
            VGA_HS      <= ~hs_act;
            VGA_VS      <= ~vs_act;
            VGA_BLANK_N <= visible;
            rgb_q       <= visible ? pal_rgb : 24'h000000;
        end
    end

    assign VGA_R   = rgb_q[23:16];
    assign VGA_G   = rgb_q[15:8];
    assign VGA_B   = rgb_q[7:0];
    assign VGA_CLK = ~pix_en;
    assign DrawX   = h_cnt;
    assign DrawY   = v_cnt;

endmodule

// File: tb/tb_frogger_vga_out.sv
// Testbench for frogger_vga_out, run with a shrunken raster so whole frames
// fit in a short run: 32 pixels x 31 lines (16/4/6/6, 24/2/2/3).
module tb_frogger_vga_out;

    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 24, VF = 2, VS = 2, VB = 3;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME_CLK = 2 * HT * VT;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic [5:0] colorcode;
    logic [9:0] DrawX, DrawY;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, frame_start;
    logic [7:0] VGA_R, VGA_G, VGA_B;

    frogger_vga_out #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .Clk(Clk), .Reset(Reset), .colorcode(colorcode),
        .DrawX(DrawX), .DrawY(DrawY), .VGA_CLK(VGA_CLK),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_start(frame_start)
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Renderer stand-in: a coordinate pattern covering all 64 codes, an
    // all-white mode, and a few pinned palette probes on line 20.
    logic       cc_white = 1'b0;
    logic       pal_test = 1'b0;
    always_comb begin
        colorcode = 6'(int'(DrawX) + 3 * int'(DrawY));
        if (cc_white) colorcode = 6'd0;
        if (pal_test && DrawY == 10'd20) begin
            case (DrawX)
                10'd8:   colorcode = 6'd63;
                10'd10:  colorcode = 6'd9;
                10'd12:  colorcode = 6'd6;
                10'd14:  colorcode = 6'd11;
                default: ;
            endcase
        end
    end

    function automatic logic [23:0] pal(input logic [5:0] c);
        case (c)
            6'd0:  return 24'hffffff;
            6'd2:  return 24'h27b212;
            6'd3:  return 24'hd80222;
            6'd4:  return 24'h5db1f0;
            6'd5:  return 24'hf1ff0a;
            6'd6:  return 24'hb2b2b0;
            6'd7:  return 24'hf27a00;
            6'd8:  return 24'h663300;
            6'd9:  return 24'h8600b3;
            6'd10: return 24'h000066;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference model: m_n counts Clk edges since Reset dropped; every
    // second edge is a pixel advance, so the raster position is simply
    // (n/2) mod the line/frame size. Outputs describe the pixel just left.
    int          m_n = 0;
    int          m_x = 0, m_y = 0;
    bit          m_ok = 1'b0;
    logic        e_hs, e_vs, e_bl, e_fs;
    logic [23:0] e_rgb;

    always @(posedge Clk) begin
        if (Reset) begin
            m_n <= 0; m_x <= 0; m_y <= 0;
            e_hs <= 1'b1; e_vs <= 1'b1; e_bl <= 1'b0; e_rgb <= 24'h0; e_fs <= 1'b0;
            m_ok <= 1'b1;
        end else begin
            m_n  <= m_n + 1;
            e_fs <= 1'b0;
            if ((m_n + 1) % 2 == 0) begin
                e_hs  <= !(m_x >= HV + HF && m_x < HV + HF + HS);
                e_vs  <= !(m_y >= VV + VF && m_y < VV + VF + VS);
                e_bl  <= (m_x < HV && m_y < VV);
                e_rgb <= (m_x < HV && m_y < VV) ? pal(colorcode) : 24'h0;
                m_x   <= ((m_n + 1) / 2) % HT;
                m_y   <= ((m_n + 1) / 2 / HT) % VT;
                e_fs  <= (((m_n + 1) / 2) % (HT * VT)) == 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (m_ok) begin
            chk("drawx", 32'(DrawX), 32'(m_x));
            chk("drawy", 32'(DrawY), 32'(m_y));
            chk("vga_clk", 32'(VGA_CLK), 32'(m_n % 2 == 0));
            chk("hs", 32'(VGA_HS), 32'(e_hs));
            chk("vs", 32'(VGA_VS), 32'(e_vs));
            chk("blank_n", 32'(VGA_BLANK_N), 32'(e_bl));
            chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e_rgb));
            chk("frame_start", 32'(frame_start), 32'(e_fs));
        end
    end

    task automatic wait_xy(input int x, input int y, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLK && !hit; i++) begin
            @(negedge Clk);
            if (int'(DrawX) == x && int'(DrawY) == y) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL wait_%s: position (%0d,%0d) never reached", tag, x, y);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_x"}, 32'(DrawX), 0);
        chk({tag, "_y"}, 32'(DrawY), 0);
        chk({tag, "_vgaclk"}, 32'(VGA_CLK), 1);
        chk({tag, "_hs"}, 32'(VGA_HS), 1);
        chk({tag, "_vs"}, 32'(VGA_VS), 1);
        chk({tag, "_blank"}, 32'(VGA_BLANK_N), 0);
        chk({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk({tag, "_fs"}, 32'(frame_start), 0);
    endtask

    initial begin
        int hs_low, bl_high, t_x, t_fall, vs_low, t1, t2;
        bit seen;
        logic [9:0] px, py;
        logic prev_hs;

        // Power-on reset
        @(negedge Clk);
        chk_reset_vals("por");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        // Reset mid-line
        wait_xy(20, 5, "mid");
        Reset = 1'b1;
        @(negedge Clk);
        chk_reset_vals("midrst");
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rel1_x", 32'(DrawX), 0);
        @(negedge Clk);
        chk("rel2_x", 32'(DrawX), 1);
        chk("rel2_y", 32'(DrawY), 0);

        // One line of horizontal timing
        wait_xy(0, 2, "line");
        hs_low = 0; bl_high = 0; t_x = -1; t_fall = -1; prev_hs = VGA_HS;
        for (int i = 0; i < 2 * HT; i++) begin
            if (i > 0) @(negedge Clk);
            if (!VGA_HS) hs_low++;
            if (VGA_BLANK_N) bl_high++;
            if (t_x < 0 && int'(DrawX) == HV + HF) t_x = i;
            if (t_fall < 0 && prev_hs && !VGA_HS) t_fall = i;
            prev_hs = VGA_HS;
        end
        chk("hs_low_clk", hs_low, 2 * HS);
        chk("blank_high_clk", bl_high, 2 * HV);
        chk("hs_fall_lag", t_fall - t_x, 2);

        // Palette probes on line 20
        pal_test = 1'b1;
        wait_xy(9, 20, "pal63");
        chk("pal63", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
        wait_xy(11, 20, "pal9");
        chk("pal9", 32'({VGA_R, VGA_G, VGA_B}), 32'h8600b3);
        wait_xy(13, 20, "pal6");
        chk("pal6", 32'({VGA_R, VGA_G, VGA_B}), 32'hb2b2b0);
        wait_xy(15, 20, "pal11");
        chk("pal11", 32'({VGA_R, VGA_G, VGA_B}), 32'h000000);
        pal_test = 1'b0;

        // All-white frame: blanking must zero RGB off-screen
        cc_white = 1'b1;
        wait_xy(6, 5, "white");
        chk("white_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'hffffff);
        chk("white_bl", 32'(VGA_BLANK_N), 1);
        wait_xy(HV + 1, 5, "hblank");
        chk("hblank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk("hblank_bl", 32'(VGA_BLANK_N), 0);
        wait_xy(3, VV + 1, "vblank");
        chk("vblank_rgb", 32'({VGA_R, VGA_G, VGA_B}), 0);
        chk("vblank_bl", 32'(VGA_BLANK_N), 0);
        repeat (FRAME_CLK) @(negedge Clk);
        cc_white = 1'b0;

        // Frame wrap and frame timing
        seen = 1'b0; px = DrawX; py = DrawY;
        for (int i = 0; i < FRAME_CLK + 8; i++) begin
            @(negedge Clk);
            if (frame_start) begin seen = 1'b1; break; end
            px = DrawX; py = DrawY;
        end
        chk("fs1_seen", 32'(seen), 1);
        t1 = cyc;
        chk("wrap_prev_x", 32'(px), HT - 1);
        chk("wrap_prev_y", 32'(py), VT - 1);
        chk("wrap_x", 32'(DrawX), 0);
        chk("wrap_y", 32'(DrawY), 0);
        @(negedge Clk);
        chk("fs1_width", 32'(frame_start), 0);
        vs_low = 0; seen = 1'b0;
        for (int i = 0; i < FRAME_CLK + 8; i++) begin
            @(negedge Clk);
            if (frame_start) begin seen = 1'b1; break; end
            if (!VGA_VS) vs_low++;
        end
        t2 = cyc;
        chk("fs2_seen", 32'(seen), 1);
        chk("fs_spacing", t2 - t1, FRAME_CLK);
        chk("vs_low_clk", vs_low, 2 * HT * VS);
        @(negedge Clk);
        chk("fs2_width", 32'(frame_start), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
